// File: rtl/motion_integrator.sv
// Tick-driven motion integrator: sums acceleration channels into speed and position,
// clamps travel, and offers whole-step deltas to a stepper driver over valid/ready.
module motion_integrator #(
  parameter int          SIM_PERIOD  = 500_000,
  parameter int          INT_BITS    = 16,
  parameter int          FRAC_BITS   = 16,
  parameter int          NUM_INPUTS  = 3,
  parameter int          SPEED_GUARD = 24,
  parameter int          SPEED_SHIFT = 4,
  parameter logic [31:0] MAX_SPEED   = 32'h0040_0000,
  parameter int          POS_MAX     = 1599
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [NUM_INPUTS*(INT_BITS+FRAC_BITS)-1:0] acc_in,
  input  logic                                       calib,
  input  logic                                       end_low,
  input  logic                                       end_high,
  output logic [INT_BITS-1:0]                        delta_steps,
  output logic                                       step_valid,
  input  logic                                       step_ready,
  output logic [INT_BITS-1:0]                        current_pos,
  output logic                                       at_low,
  output logic                                       at_high,
  output logic                                       calib_fault,
  output logic                                       sync_tick
);

  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int SW = W + SPEED_GUARD;
  localparam int CW = $clog2(SIM_PERIOD);
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  localparam logic [W-1:0]         ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         ACC_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [SW:0]   SPD_HI  = (SW+1)'(MAX_SPEED);
  localparam logic signed [SW:0]   SPD_LO  = -SPD_HI;
  localparam logic signed [SW:0]   POS_LIM = (SW+1)'(POS_MAX);
  localparam logic signed [SW-1:0] POS_TOP = SW'(POS_MAX) << FRAC_BITS;

  typedef enum logic [2:0] {S_IDLE, S_SUM, S_VEL, S_POS, S_CALIB, S_PUB} state_t;

  state_t                r_state, w_state_next;
  logic [CW-1:0]         r_tick_cnt;
  logic                  w_tick;
  logic                  w_xfer;

  logic [W-1:0]          r_acc, w_acc_next;
  logic [IW-1:0]         r_idx, w_idx_next;
  logic signed [SW-1:0]  r_speed, w_speed_next;
  logic signed [SW-1:0]  r_pos, w_pos_next;
  logic                  r_cal_tick, w_cal_tick_next;
  logic                  r_lim_low, w_lim_low_next;
  logic                  r_lim_high, w_lim_high_next;
  logic                  r_at_low, w_at_low_next;
  logic                  r_at_high, w_at_high_next;
  logic                  r_calib_fault, w_fault_next;
  logic [INT_BITS-1:0]   r_cur_pos, w_cur_next;
  logic [INT_BITS-1:0]   r_delta, w_delta_next;
  logic                  r_valid, w_valid_next;

  logic [W-1:0]          w_ch [NUM_INPUTS];
  logic [W-1:0]          w_ch_sel;
  logic [W:0]            w_sum_wide;
  logic [W-1:0]          w_acc_sat;
  logic signed [SW:0]    w_spd_wide;
  logic signed [SW-1:0]  w_speed_clamp;
  logic signed [SW-1:0]  w_spd_shr;
  logic signed [SW:0]    w_pos_wide;
  logic signed [SW:0]    w_pos_int;
  logic [INT_BITS-1:0]   w_pos_steps;
  logic [INT_BITS-1:0]   w_new_delta;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ch
    assign w_ch[gi] = acc_in[gi*W +: W];
  end

  assign w_tick   = (r_tick_cnt == CW'(SIM_PERIOD - 1));
  assign w_xfer   = r_valid & step_ready;
  assign w_ch_sel = w_ch[r_idx];

  // Saturating channel sum: overflow shows as disagreement of the two top bits.
  assign w_sum_wide = {r_acc[W-1], r_acc} + {w_ch_sel[W-1], w_ch_sel};
  assign w_acc_sat  = (w_sum_wide[W] != w_sum_wide[W-1]) ?
                      (w_sum_wide[W] ? ACC_MIN : ACC_MAX) : w_sum_wide[W-1:0];

  assign w_spd_wide    = {r_speed[SW-1], r_speed} + {{(SW+1-W){r_acc[W-1]}}, r_acc};
  assign w_speed_clamp = (w_spd_wide > SPD_HI) ? SPD_HI[SW-1:0] :
                         (w_spd_wide < SPD_LO) ? SPD_LO[SW-1:0] : w_spd_wide[SW-1:0];

  assign w_spd_shr   = r_speed >>> SPEED_SHIFT;
  assign w_pos_wide  = {r_pos[SW-1], r_pos} + {w_spd_shr[SW-1], w_spd_shr};
  assign w_pos_int   = w_pos_wide >>> FRAC_BITS;
  assign w_pos_steps = r_pos[FRAC_BITS +: INT_BITS];
  assign w_new_delta = r_cal_tick ? INT_BITS'(1) : (w_pos_steps - r_cur_pos);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_tick) w_state_next = calib ? S_CALIB : S_SUM;
      S_SUM:   if (r_idx == IW'(NUM_INPUTS - 1)) w_state_next = S_VEL;
      S_VEL:   w_state_next = S_POS;
      S_POS:   w_state_next = S_PUB;
      S_CALIB: w_state_next = S_PUB;
      S_PUB:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_acc_next      = r_acc;
    w_idx_next      = r_idx;
    w_speed_next    = r_speed;
    w_pos_next      = r_pos;
    w_cal_tick_next = r_cal_tick;
    w_lim_low_next  = r_lim_low;
    w_lim_high_next = r_lim_high;
    w_at_low_next   = r_at_low;
    w_at_high_next  = r_at_high;
    w_fault_next    = r_calib_fault;
    w_cur_next      = r_cur_pos;
    w_delta_next    = r_delta;
    w_valid_next    = r_valid & ~w_xfer;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_acc_next      = '0;
          w_idx_next      = '0;
          w_cal_tick_next = calib;
        end
      end
      S_SUM: begin
        w_acc_next = w_acc_sat;
        w_idx_next = r_idx + IW'(1);
      end
      S_VEL: w_speed_next = w_speed_clamp;
      S_POS: begin
        if (w_pos_wide[SW]) begin
          w_pos_next      = '0;
          w_lim_low_next  = 1'b1;
          w_lim_high_next = 1'b0;
          if (r_speed[SW-1]) w_speed_next = '0;
        end else if (w_pos_int > POS_LIM) begin
          w_pos_next      = POS_TOP;
          w_lim_low_next  = 1'b0;
          w_lim_high_next = 1'b1;
          if (!r_speed[SW-1] && r_speed != '0) w_speed_next = '0;
        end else begin
          w_pos_next      = w_pos_wide[SW-1:0];
          w_lim_low_next  = 1'b0;
          w_lim_high_next = 1'b0;
        end
      end
      S_CALIB: begin
        w_speed_next = '0;
        if (end_low && !end_high)      w_pos_next   = '0;
        else if (end_high && !end_low) w_pos_next   = POS_TOP;
        else if (end_low && end_high)  w_fault_next = 1'b1;
      end
      S_PUB: begin
        w_cur_next = w_pos_steps;
        if (!r_cal_tick) begin
          w_at_low_next  = r_lim_low;
          w_at_high_next = r_lim_high;
        end
        // An unaccepted offer absorbs the new delta so no steps are lost.
        w_delta_next = (r_valid && !w_xfer) ? (r_delta + w_new_delta) : w_new_delta;
        w_valid_next = (w_delta_next != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc         <= '0;
      r_idx         <= '0;
      r_speed       <= '0;
      r_pos         <= '0;
      r_cal_tick    <= 1'b0;
      r_lim_low     <= 1'b0;
      r_lim_high    <= 1'b0;
      r_at_low      <= 1'b0;
      r_at_high     <= 1'b0;
      r_calib_fault <= 1'b0;
      r_cur_pos     <= '0;
      r_delta       <= '0;
      r_valid       <= 1'b0;
    end else begin
      r_acc         <= w_acc_next;
      r_idx         <= w_idx_next;
      r_speed       <= w_speed_next;
      r_pos         <= w_pos_next;
      r_cal_tick    <= w_cal_tick_next;
      r_lim_low     <= w_lim_low_next;
      r_lim_high    <= w_lim_high_next;
      r_at_low      <= w_at_low_next;
      r_at_high     <= w_at_high_next;
      r_calib_fault <= w_fault_next;
      r_cur_pos     <= w_cur_next;
      r_delta       <= w_delta_next;
      r_valid       <= w_valid_next;
    end
  end

  assign delta_steps = r_delta;
  assign step_valid  = r_valid;
  assign current_pos = r_cur_pos;
  assign at_low      = r_at_low;
  assign at_high     = r_at_high;
  assign calib_fault = r_calib_fault;
  assign sync_tick   = w_tick;

endmodule

// File: tb/tb_motion_integrator.sv
// Bench for motion_integrator: directed scenarios plus randomized ticks checked
// every cycle against a tick-level arithmetic model of the integrator and handshake.
module tb_motion_integrator;
  localparam int P = 16;
  localparam int N = 3;
  localparam int FB = 16;
  localparam int W = 32;
  localparam int SHIFT = 0;
  localparam int PMAX = 1599;
  localparam longint MAXSPD = 64'sh0004_0000;
  localparam logic [W-1:0] ONE  = 32'h0001_0000;
  localparam logic [W-1:0] MONE = 32'hFFFF_0000;
  localparam logic [W-1:0] BIG  = 32'h7FFF_0000;
  localparam logic [W-1:0] ZERO = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N*W-1:0] acc_in = '0;
  logic calib = 1'b0, end_low = 1'b0, end_high = 1'b0, step_ready = 1'b0;
  logic [15:0] delta_steps, current_pos;
  logic step_valid, at_low, at_high, calib_fault, sync_tick;

  always #5 clock = ~clock;

  motion_integrator #(
    .SIM_PERIOD(P), .INT_BITS(16), .FRAC_BITS(FB), .NUM_INPUTS(N), .SPEED_GUARD(24),
    .SPEED_SHIFT(SHIFT), .MAX_SPEED(32'h0004_0000), .POS_MAX(PMAX)
  ) dut (
    .clock(clock), .reset(reset), .acc_in(acc_in), .calib(calib),
    .end_low(end_low), .end_high(end_high), .delta_steps(delta_steps),
    .step_valid(step_valid), .step_ready(step_ready), .current_pos(current_pos),
    .at_low(at_low), .at_high(at_high), .calib_fault(calib_fault), .sync_tick(sync_tick)
  );

  int total = 0;
  int bad = 0;

  // Reference state
  longint m_speed, m_pos;
  int m_cnt, m_cd, m_cur, n_cur;
  bit m_busy, m_is_cal, m_valid, m_low, m_high, m_fault, n_low, n_high, n_fault, pub_seen;
  shortint m_delta;
  int rdy_mode = 0;
  int d_xcount = 0;
  logic [15:0] d_xlast = '0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_speed = 0; m_pos = 0; m_cnt = 0; m_cd = 0; m_cur = 0; n_cur = 0;
    m_busy = 0; m_is_cal = 0; m_valid = 0; m_low = 0; m_high = 0; m_fault = 0;
    n_low = 0; n_high = 0; n_fault = 0; m_delta = 0;
  endtask

  task automatic check_all();
    chk("sync_tick", sync_tick, 16'(m_cnt == P - 1));
    chk("step_valid", step_valid, 16'(m_valid));
    if (m_valid) chk("delta_steps", delta_steps, 16'(m_delta));
    chk("current_pos", current_pos, 16'(m_cur));
    chk("at_low", at_low, 16'(m_low));
    chk("at_high", at_high, 16'(m_high));
    chk("calib_fault", calib_fault, 16'(m_fault));
  endtask

  // One tick of physics, computed at the edge that samples sync_tick.
  task automatic start_tick();
    longint a;
    m_is_cal = calib;
    if (calib) begin
      m_speed = 0;
      if (end_low && !end_high) m_pos = 0;
      else if (end_high && !end_low) m_pos = longint'(PMAX) * 65536;
      n_fault = end_low && end_high;
      m_cd = 2;
    end else begin
      a = 0;
      for (int k = 0; k < N; k++) begin
        a = a + longint'(signed'(acc_in[k*W +: W]));
        if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
        if (a < -64'sh8000_0000) a = -64'sh8000_0000;
      end
      m_speed = m_speed + a;
      if (m_speed > MAXSPD) m_speed = MAXSPD;
      if (m_speed < -MAXSPD) m_speed = -MAXSPD;
      m_pos = m_pos + (m_speed >>> SHIFT);
      n_low = 0; n_high = 0;
      if (m_pos < 0) begin
        m_pos = 0; n_low = 1;
        if (m_speed < 0) m_speed = 0;
      end else if ((m_pos >>> FB) > PMAX) begin
        m_pos = longint'(PMAX) * 65536; n_high = 1;
        if (m_speed > 0) m_speed = 0;
      end
      m_cd = N + 3;
    end
    n_cur = int'(m_pos >>> FB);
    m_busy = 1;
  endtask

  task automatic publish(input bit xfer);
    shortint nd;
    nd = m_is_cal ? shortint'(1) : shortint'(n_cur - m_cur);
    if (m_valid && !xfer) m_delta = m_delta + nd;
    else m_delta = nd;
    m_valid = (m_delta != 0);
    m_cur = n_cur;
    if (!m_is_cal) begin m_low = n_low; m_high = n_high; end
  endtask

  // Advance one clock: update the model for this edge, then check all outputs.
  task automatic cyc();
    bit xfer;
    if (step_valid === 1'b1 && step_ready === 1'b1) begin
      d_xcount++; d_xlast = delta_steps;
    end
    @(posedge clock);
    xfer = m_valid && step_ready;
    if (m_busy) begin
      m_cd--;
      if (m_is_cal && m_cd == 1 && n_fault) m_fault = 1;
      if (m_cd == 0) begin publish(xfer); m_busy = 0; pub_seen = 1; end
      else if (xfer) m_valid = 0;
    end else if (xfer) m_valid = 0;
    if (m_cnt == P - 1) begin start_tick(); m_cnt = 0; end
    else m_cnt++;
    @(negedge clock);
    check_all();
    if (rdy_mode == 1) step_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    model_clear();
    check_all();
    reset = 1'b0;
  endtask

  task automatic tick(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [W-1:0] c2,
                      input bit cal, input bit el, input bit eh);
    acc_in = {c2, c1, c0}; calib = cal; end_low = el; end_high = eh;
    pub_seen = 0;
    for (int i = 0; i < 3 * P && !pub_seen; i++) cyc();
  endtask

  task automatic wait_sync();
    int g;
    g = 0;
    while (sync_tick !== 1'b1 && g < 2 * P) begin cyc(); g++; end
    chk("sync_wait", sync_tick, 16'h1);
  endtask

  function automatic logic [W-1:0] rnd_ch(input bit wild);
    if (wild) return W'($urandom);
    return W'(int'($urandom_range(0, 32'h30000)) - 32'sh18000);
  endfunction

  initial begin
    int pulses, d0;
    int exp_d[4] = '{2, 3, 4, 4};
    int exp_c[4] = '{3, 6, 10, 14};
    model_clear();
    @(negedge clock);

    // Reset state and tick cadence with idle inputs
    do_reset();
    step_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5 * P; i++) begin cyc(); if (sync_tick === 1'b1) pulses++; end
    chk("sync_pulses", 16'(pulses), 16'd5);

    // Constant 1.0 acceleration: latency, then 1,3,6 and the speed clamp at 4
    do_reset();
    acc_in = {ZERO, ZERO, ONE};
    wait_sync();
    repeat (N + 3) cyc();
    chk("lat_before", current_pos, 16'd0);
    cyc();
    chk("lat_pos", current_pos, 16'd1);
    chk("lat_delta", delta_steps, 16'd1);
    for (int k = 0; k < 4; k++) begin
      tick(ONE, ZERO, ZERO, 0, 0, 0);
      chk("ramp_delta", delta_steps, 16'(exp_d[k]));
      chk("ramp_pos", current_pos, 16'(exp_c[k]));
    end

    // Saturating sum stays positive
    do_reset();
    tick(BIG, BIG, ZERO, 0, 0, 0);
    chk("sat_delta", delta_steps, 16'd4);
    chk("sat_low", at_low, 16'd0);
    tick(BIG, BIG, BIG, 0, 0, 0);
    chk("sat3_pos", current_pos, 16'd8);

    // Low bound holds position and speed at zero
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick(MONE, ZERO, ZERO, 0, 0, 0);
      chk("low_flag", at_low, 16'd1);
      chk("low_pos", current_pos, 16'd0);
      chk("low_valid", step_valid, 16'd0);
    end
    tick(ONE, ZERO, ZERO, 0, 0, 0);
    chk("low_release", delta_steps, 16'd1);

    // Backpressure coalesces into a single transfer
    do_reset();
    step_ready = 1'b0;
    tick(ONE, ZERO, ZERO, 0, 0, 0); chk("bp1", delta_steps, 16'd1);
    tick(ONE, ZERO, ZERO, 0, 0, 0); chk("bp2", delta_steps, 16'd3);
    tick(ONE, ZERO, ZERO, 0, 0, 0); chk("bp3", delta_steps, 16'd6);
    chk("bp_valid", step_valid, 16'd1);
    d0 = d_xcount;
    step_ready = 1'b1;
    repeat (3) cyc();
    chk("bp_drop", step_valid, 16'd0);
    chk("bp_count", 16'(d_xcount - d0), 16'd1);
    chk("bp_value", d_xlast, 16'd6);

    // Calibration and homing
    do_reset();
    step_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(ZERO, ZERO, ZERO, 1, 0, 0);
      chk("cal_delta", delta_steps, 16'd1);
      chk("cal_pos", current_pos, 16'd0);
    end
    tick(ONE, ONE, ONE, 1, 0, 1);
    chk("home_pos", current_pos, 16'd1599);
    chk("home_delta", delta_steps, 16'd1);
    tick(ZERO, ZERO, ZERO, 0, 0, 0);
    chk("home_still", step_valid, 16'd0);
    chk("home_keep", current_pos, 16'd1599);
    tick(ZERO, ZERO, ZERO, 1, 1, 1);
    chk("fault_set", calib_fault, 16'd1);
    chk("fault_pos", current_pos, 16'd1599);
    do_reset();
    chk("fault_clr", calib_fault, 16'd0);

    // Reset in the middle of a tick discards the pending offer
    step_ready = 1'b0;
    tick(ONE, ZERO, ZERO, 0, 0, 0);
    wait_sync();
    repeat (2) cyc();
    do_reset();
    chk("mid_valid", step_valid, 16'd0);
    step_ready = 1'b1;
    tick(ONE, ZERO, ZERO, 0, 0, 0);
    chk("mid_restart", delta_steps, 16'd1);

    // Randomized ticks with random backpressure
    rdy_mode = 1;
    for (int t = 0; t < 450; t++) begin
      bit wild;
      wild = ($urandom_range(0, 9) == 0);
      tick(rnd_ch(wild), rnd_ch(wild), rnd_ch(wild), $urandom_range(0, 11) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    step_ready = 1'b1;
    repeat (P) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/motion_integrator.md
# motion_integrator

Parametrised successor to the fixed three-input balance simulator. It integrates the signed sum of `NUM_INPUTS` fixed-point accelerations into speed and position once per simulation tick. It clamps speed and travel and publishes whole-step position deltas to the stepper driver over a valid/ready handshake. It runs entirely in the system clock domain with a tick enable, has no derived clock, and adds a calibration/homing mode driven by the end switches.

## Interface
- `SIM_PERIOD`, 500_000: system clocks per simulation tick; must be > `NUM_INPUTS`+4.
- `INT_BITS`, 16: integer bits of accelerations and steps.
- `FRAC_BITS`, 16: fractional bits; W = `INT_BITS`+`FRAC_BITS`.
- `NUM_INPUTS`, 3: acceleration channels.
- `SPEED_GUARD`, 24: extra speed/position bits; SW = W+`SPEED_GUARD`.
- `SPEED_SHIFT`, 4: arithmetic right shift applied to speed before adding it to position.
- `MAX_SPEED`, 32'h0040_0000: speed magnitude limit, in speed LSBs.
- `POS_MAX`, 1599: upper travel limit, in whole steps.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `acc_in` in `NUM_INPUTS`*W: flattened signed Q`INT_BITS`.`FRAC_BITS` accelerations; channel k is at [k*W +: W].
- `calib` in 1: calibration mode, sampled at tick.
- `end_low` in 1: low end switch.
- `end_high` in 1: high end switch.
- `delta_steps` out `INT_BITS`: signed step delta offered to the driver.
- `step_valid` out 1: `delta_steps` is valid.
- `step_ready` in 1: driver accepts.
- `current_pos` out `INT_BITS`: integer position in steps.
- `at_low` out 1, `at_high` out 1: clamp flags, updated each tick.
- `calib_fault` out 1: sticky; set when both end switches are seen during calibration.
- `sync_tick` out 1: one-cycle pulse at each tick.

## Operation
- Tick counter runs 0..`SIM_PERIOD`-1. `sync_tick` is 1 when count = `SIM_PERIOD`-1, then the counter wraps to 0.
- FSM states:
  - IDLE: on `sync_tick`, go to CALIB if `calib`=1, else to SUM with acc=0 and idx=0.
  - SUM: one channel per cycle, acc = sat_W(acc + ch[idx]). Saturation limits are 0x7FFF…F and 0x800…0. After idx = `NUM_INPUTS`-1, go to VEL.
  - VEL: speed (SW signed) += sign-extended acc, then clamp to ±`MAX_SPEED`. Go to POS.
  - POS: pos (SW signed; integer part = pos >>> `FRAC_BITS`) += speed >>> `SPEED_SHIFT`. Then apply limits:
    - pos < 0: pos = 0, speed = max(speed, 0), `at_low`=1.
    - int(pos) > `POS_MAX`: pos = `POS_MAX` << `FRAC_BITS`, speed = min(speed, 0), `at_high`=1.
    - Otherwise both flags are 0.
    - Go to PUB.
  - CALIB: speed = 0 and new_delta = +1.
    - `end_low` only: pos = 0.
    - `end_high` only: pos = `POS_MAX` << `FRAC_BITS`.
    - Both: pos unchanged, `calib_fault`=1.
    - Go to PUB.
  - PUB: new_delta = int(pos) − `current_pos` (CALIB supplies +1). Update `current_pos` = int(pos). Publish new_delta (rules below). Return to IDLE.
- Publish rules:
  - If `step_valid`=1 and the handshake did not complete this cycle: `delta_steps` += new_delta (coalesce, wrap-free because range is bounded).
  - Otherwise `delta_steps` = new_delta.
  - `step_valid` = (resulting `delta_steps` ≠ 0).
- Handshake:
  - A transfer is `step_valid` & `step_ready` on a rising edge.
  - After a transfer, `step_valid` drops next cycle unless PUB reloads it in the same cycle.
  - `delta_steps` is stable while `step_valid`=1 and `step_ready`=0, except for coalescing in PUB.

## Timing
- Reset values: every output is 0; speed, pos, acc, tick count are 0; FSM is in IDLE.
- Reset mid-computation aborts the in-progress tick; any pending delta is discarded.
- Latency from `sync_tick` to updated `delta_steps`/`step_valid`/`current_pos` is `NUM_INPUTS`+3 clocks.
- `acc_in`, `calib` and the end switches are sampled during the SUM/CALIB cycles. They must be stable from `sync_tick` until PUB.
- The driver may hold `step_ready` high permanently.

## Test plan
- Reset, then `SIM_PERIOD`=1000: `sync_tick` pulses every 1000 clocks. All outputs stay 0 with zero inputs.
- `SPEED_SHIFT`=0, `POS_MAX`=1599, ch0=0x0001_0000, others 0, `step_ready`=1:
  - Deltas are +1, +2, +3.
  - `current_pos` is 1, 3, 6.
  - Each result appears `NUM_INPUTS`+3 clocks after its tick.
- Same setup with `MAX_SPEED`=0x0004_0000: speed holds at 4.0 from tick 4, and delta is +4 every tick thereafter.
- Saturation and low bound:
  - Three channels at 0x7FFF_0000 give a summed acc of 0x7FFF_FFFF.
  - ch0=0xFFFF_0000 from pos 0: pos stays 0, speed stays 0, `at_low`=1, `step_valid` never rises.
- Backpressure, `SPEED_SHIFT`=0, acc=1.0, `step_ready`=0 for 3 ticks:
  - `delta_steps` reads 1, 3, 6 with `step_valid` held high.
  - Raising `step_ready` gives exactly one transfer of 6.
- Calibration, `calib`=1:
  - Delta is +1 per tick.
  - An `end_high` pulse gives `current_pos`=1599 and speed 0.
  - `end_low` and `end_high` together set `calib_fault`=1 and leave pos unchanged.
  - Asserting `reset` clears `calib_fault`.
